// File: rtl/mc_ctrl_fsm_pkg.sv
// rtl/mc_ctrl_fsm_pkg.sv - shared encodings for the multi-cycle sequencer and decoder
package mc_ctrl_fsm_pkg;

    // RV32I major opcodes handled by the multi-cycle datapath
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Next-PC select, shared with the datapath mux
    localparam logic [1:0] NPC_PLUS4  = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    // Register write-data select, driven by the decoder
    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    // Fault codes reported on trap_cause
    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_BUS     = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_ITYPE, OP_LUI, OP_LOAD,
            OP_STORE, OP_BRANCH, OP_JAL: is_legal_op = 1'b1;
            default:                     is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - shared memory port handshake between sequencer and memory
interface mc_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait counter with timeout compare
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic busy,
    input  logic ready,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear on a new request or completion, otherwise count stalled request cycles
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (busy && ready) begin
            cnt_d = '0;
        end else if (busy) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A ready arriving on the limit cycle is a normal completion, not a timeout
    assign expired = busy && !ready && (cnt_q == LIMIT);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle RV32I sequencer sharing one memory port
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [6:0]          op,
    input  logic [2:0]          funct3,
    input  logic                zero,
    mc_ctrl_fsm_if.master       mem,
    output logic                ir_we,
    output logic                pc_we,
    output logic [1:0]          npc_sel,
    output logic                reg_we,
    output logic                retire,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [2:0]          state_o
);

    state_t     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       req, we, asel;
    logic       timer_start;
    logic       expired;
    logic       unused_funct3;

    // Branch type is not distinguished here; the decoder owns funct3 filtering
    assign unused_funct3 = ^funct3;

    // State and trap cause registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    // Next-state sequencing, including illegal-op and bus-timeout traps
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem.mem_ready) begin
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            ST_DECODE: begin
                if (is_legal_op(op)) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            ST_EXEC: begin
                if (op == OP_BRANCH) begin
                    state_d = ST_FETCH;
                end else if (op == OP_LOAD || op == OP_STORE) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem.mem_ready) begin
                    state_d = (op == OP_STORE) ? ST_FETCH : ST_WB;
                end else if (expired) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_BUS;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Strobes and memory handshake decoded from the current state
    always_comb begin
        req     = 1'b0;
        we      = 1'b0;
        asel    = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        npc_sel = NPC_PLUS4;
        reg_we  = 1'b0;
        retire  = 1'b0;
        trap    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                req   = 1'b1;
                ir_we = mem.mem_ready;
            end
            ST_EXEC: begin
                if (op == OP_BRANCH) begin
                    pc_we   = 1'b1;
                    npc_sel = zero ? NPC_BRANCH : NPC_PLUS4;
                    retire  = 1'b1;
                end
            end
            ST_MEM: begin
                req  = 1'b1;
                asel = 1'b1;
                we   = (op == OP_STORE);
                if (mem.mem_ready && op == OP_STORE) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                npc_sel = (op == OP_JAL) ? NPC_JUMP : NPC_PLUS4;
            end
            ST_TRAP:  trap = 1'b1;
            default:  ;
        endcase
    end

    assign mem.mem_req  = req;
    assign mem.mem_we   = we;
    assign mem.addr_sel = asel;
    assign trap_cause   = cause_q;
    assign state_o      = state_q;

    // Restart the wait count whenever a fresh memory request phase begins
    assign timer_start = (state_d == ST_FETCH || state_d == ST_MEM) && (state_d != state_q);

    mc_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rstn    (rstn),
        .start   (timer_start),
        .busy    (req),
        .ready   (mem.mem_ready),
        .expired (expired)
    );

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed-vector bench for the multi-cycle sequencer
module tb_mc_ctrl_fsm;

    localparam logic [6:0] ADD  = 7'b0110011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] BAD  = 7'h7F;

    // {mem_req, mem_we, addr_sel, ir_we, pc_we, npc_sel[1:0], reg_we, retire, trap}
    localparam logic [9:0] O_NONE   = 10'b0000000000;
    localparam logic [9:0] O_FET_W  = 10'b1000000000;
    localparam logic [9:0] O_FET_R  = 10'b1001000000;
    localparam logic [9:0] O_MEM_LD = 10'b1010000000;
    localparam logic [9:0] O_MEM_SW = 10'b1110000000;
    localparam logic [9:0] O_MEM_SR = 10'b1110100010;
    localparam logic [9:0] O_WB     = 10'b0000100110;
    localparam logic [9:0] O_WB_JAL = 10'b0000110110;
    localparam logic [9:0] O_BEQ_T  = 10'b0000101010;
    localparam logic [9:0] O_BEQ_N  = 10'b0000100010;
    localparam logic [9:0] O_TRAP   = 10'b0000000001;

    logic       clk = 1'b0;
    logic       rstn;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       ir_we, pc_we, reg_we, retire, trap;
    logic [1:0] npc_sel, trap_cause;
    logic [2:0] state_o;
    logic [9:0] outs;
    int         n_vec = 0;
    int         n_bad = 0;

    mc_ctrl_fsm_if mem_bus ();

    mc_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .op         (op),
        .funct3     (funct3),
        .zero       (zero),
        .mem        (mem_bus),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .npc_sel    (npc_sel),
        .reg_we     (reg_we),
        .retire     (retire),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    assign outs = {mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel, ir_we, pc_we,
                   npc_sel, reg_we, retire, trap};

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, then check state and strobes
    task automatic cyc(input string tag, input logic [6:0] o, input logic z, input logic r,
                       input logic [2:0] exp_st, input logic [9:0] exp_out);
        @(negedge clk);
        op = o;
        zero = z;
        mem_bus.mem_ready = r;
        #1;
        check_vec({tag, ".state"}, 32'(state_o), 32'(exp_st));
        check_vec({tag, ".outs"}, 32'(outs), 32'(exp_out));
    endtask

    initial begin
        rstn = 1'b0;
        op = 7'd0;
        funct3 = 3'd0;
        zero = 1'b0;
        mem_bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_vec("reset.state", 32'(state_o), 32'd0);
        check_vec("reset.outs", 32'(outs), 32'(O_NONE));
        check_vec("reset.cause", 32'(trap_cause), 32'd0);
        rstn = 1'b1;

        // add, zero-wait memory: 4 cycles
        cyc("add.f", ADD, 1'b0, 1'b1, 3'd1, O_FET_R);
        cyc("add.d", ADD, 1'b0, 1'b0, 3'd2, O_NONE);
        cyc("add.e", ADD, 1'b0, 1'b0, 3'd3, O_NONE);
        cyc("add.w", ADD, 1'b0, 1'b0, 3'd5, O_WB);

        // lw with 3 wait cycles in MEM: 8 cycles, ready outside a request ignored
        cyc("lw.f",  LW, 1'b0, 1'b1, 3'd1, O_FET_R);
        cyc("lw.d",  LW, 1'b0, 1'b1, 3'd2, O_NONE);
        cyc("lw.e",  LW, 1'b0, 1'b1, 3'd3, O_NONE);
        cyc("lw.m0", LW, 1'b0, 1'b0, 3'd4, O_MEM_LD);
        cyc("lw.m1", LW, 1'b0, 1'b0, 3'd4, O_MEM_LD);
        cyc("lw.m2", LW, 1'b0, 1'b0, 3'd4, O_MEM_LD);
        cyc("lw.m3", LW, 1'b0, 1'b1, 3'd4, O_MEM_LD);
        cyc("lw.w",  LW, 1'b0, 1'b0, 3'd5, O_WB);

        // beq taken and not taken: 3 cycles
        cyc("beqt.f", BEQ, 1'b1, 1'b1, 3'd1, O_FET_R);
        cyc("beqt.d", BEQ, 1'b1, 1'b0, 3'd2, O_NONE);
        cyc("beqt.e", BEQ, 1'b1, 1'b0, 3'd3, O_BEQ_T);
        cyc("beqn.f", BEQ, 1'b0, 1'b1, 3'd1, O_FET_R);
        cyc("beqn.d", BEQ, 1'b0, 1'b0, 3'd2, O_NONE);
        cyc("beqn.e", BEQ, 1'b0, 1'b0, 3'd3, O_BEQ_N);

        // jal: jump select in WB
        cyc("jal.f", JAL, 1'b0, 1'b1, 3'd1, O_FET_R);
        cyc("jal.d", JAL, 1'b0, 1'b0, 3'd2, O_NONE);
        cyc("jal.e", JAL, 1'b0, 1'b0, 3'd3, O_NONE);
        cyc("jal.w", JAL, 1'b0, 1'b0, 3'd5, O_WB_JAL);

        // sw with one wait cycle: mem_we only in MEM, retire on completion
        cyc("sw.f",  SW, 1'b0, 1'b1, 3'd1, O_FET_R);
        cyc("sw.d",  SW, 1'b0, 1'b0, 3'd2, O_NONE);
        cyc("sw.e",  SW, 1'b0, 1'b0, 3'd3, O_NONE);
        cyc("sw.m0", SW, 1'b0, 1'b0, 3'd4, O_MEM_SW);
        cyc("sw.m1", SW, 1'b0, 1'b1, 3'd4, O_MEM_SR);

        // ready arriving on the 16th request cycle completes normally
        for (int i = 1; i <= 15; i++) begin
            cyc($sformatf("lim.f%0d", i), ADD, 1'b0, 1'b0, 3'd1, O_FET_W);
        end
        cyc("lim.f16", ADD, 1'b0, 1'b1, 3'd1, O_FET_R);
        cyc("lim.d",   ADD, 1'b0, 1'b0, 3'd2, O_NONE);
        cyc("lim.e",   ADD, 1'b0, 1'b0, 3'd3, O_NONE);
        cyc("lim.w",   ADD, 1'b0, 1'b0, 3'd5, O_WB);

        // illegal opcode traps after DECODE; later ready pulses ignored
        cyc("ill.f", BAD, 1'b0, 1'b1, 3'd1, O_FET_R);
        cyc("ill.d", BAD, 1'b0, 1'b0, 3'd2, O_NONE);
        cyc("ill.t0", BAD, 1'b0, 1'b1, 3'd6, O_TRAP);
        cyc("ill.t1", ADD, 1'b0, 1'b0, 3'd6, O_TRAP);
        cyc("ill.t2", ADD, 1'b0, 1'b1, 3'd6, O_TRAP);
        check_vec("ill.cause", 32'(trap_cause), 32'd1);

        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_vec("rst1.state", 32'(state_o), 32'd0);
        check_vec("rst1.cause", 32'(trap_cause), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // fetch never answered: trap after the 16th request cycle
        for (int i = 1; i <= 16; i++) begin
            cyc($sformatf("to.f%0d", i), ADD, 1'b0, 1'b0, 3'd1, O_FET_W);
        end
        cyc("to.t0", ADD, 1'b0, 1'b0, 3'd6, O_TRAP);
        check_vec("to.cause", 32'(trap_cause), 32'd2);
        cyc("to.t1", ADD, 1'b0, 1'b1, 3'd6, O_TRAP);

        // reset asserted mid-TRAP
        #2;
        rstn = 1'b0;
        #1;
        check_vec("rst2.state", 32'(state_o), 32'd0);
        check_vec("rst2.outs", 32'(outs), 32'(O_NONE));
        check_vec("rst2.cause", 32'(trap_cause), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // reset asserted mid-request drops mem_req at once
        cyc("rq.f", SW, 1'b0, 1'b0, 3'd1, O_FET_W);
        #2;
        rstn = 1'b0;
        #1;
        check_vec("rq.outs", 32'(outs), 32'(O_NONE));
        check_vec("rq.state", 32'(state_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle sequencer for the RV32I datapath: FETCH → DECODE → EXEC → MEM → WB.
- Shares one memory port between instruction fetch and data access.
- Works beside the existing combinational instruction decoder. The decoder still supplies ALUOp/EXTOp. This block times the write strobes, PC update, IR load and memory handshake.

Parameters:
- MEM_TIMEOUT, 16: max cycles mem_req may wait for mem_ready before bus-error trap; legal range 2..255.
- CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- op  in  7  opcode from IR[6:0]
- funct3  in  3  IR[14:12]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  write qualifier for mem_req
- addr_sel  out  1  0 = PC, 1 = ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  PC update strobe
- npc_sel  out  2  00 = PC+4, 01 = branch, 10 = jump (shared NPC encoding)
- reg_we  out  1  register-file write strobe
- retire  out  1  one-cycle pulse per completed instruction
- trap  out  1  sticky fault flag
- trap_cause  out  2  01 = illegal opcode, 10 = bus timeout
- state_o  out  3  current state, debug

Behaviour:
- States: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6. Registered state. Outputs are combinational from state, op, zero and mem_ready.
- Reset (rstn low, async): state = IDLE, counter = 0, trap = 0, trap_cause = 0. All outputs are 0 while in IDLE.
- IDLE → FETCH on the first clk edge after rstn deasserts.
- FETCH:
  - mem_req = 1, addr_sel = 0, mem_we = 0.
  - On mem_ready: ir_we = 1 that cycle, then → DECODE.
- DECODE: one cycle, no strobes. Legal ops are 0110011, 0010011, 0110111, 0000011, 0100011, 1100011, 1101111.
  - Any other op → TRAP with cause 01.
  - Legal op → EXEC.
- EXEC: one cycle.
  - beq (1100011): pc_we = 1, npc_sel = zero ? 01 : 00, retire = 1, → FETCH.
  - Load or store: → MEM.
  - All other legal ops: → WB.
  - Other funct3 under 1100011 is treated as beq; funct3 filtering belongs to the decoder.
- MEM:
  - mem_req = 1, addr_sel = 1, mem_we = 1 for store only.
  - On mem_ready, store: pc_we = 1, npc_sel = 00, retire = 1, → FETCH.
  - On mem_ready, load: → WB.
- WB: reg_we = 1, pc_we = 1, retire = 1, npc_sel = 10 for jal else 00, → FETCH.
  - PC is written in the same cycle reg_we writes PC+4 for jal, so the old PC is still valid.
- Handshake:
  - Once asserted, mem_req, mem_we and addr_sel stay stable until the mem_ready cycle.
  - mem_ready while mem_req = 0 is ignored.
  - Zero-wait memory is legal (mem_ready in the first request cycle).
- Timeout counter:
  - Clears on entry to FETCH/MEM and on mem_ready.
  - Increments each request cycle without mem_ready.
  - Reaching MEM_TIMEOUT-1 with mem_ready still low → TRAP with cause 10, mem_req drops next cycle.
  - mem_ready in the same cycle as the limit wins (normal completion).
- TRAP: absorbing. All strobes 0, trap = 1, trap_cause held. Only rstn exits.
- Latency with zero-wait memory:
  - beq: 3 cycles
  - ALU ops, LUI, jal, store: 4 cycles
  - load: 5 cycles
  - Each wait cycle adds 1.
- Reset mid-request: mem_req deasserts asynchronously; no partial write strobe survives.

Decomposition:
- Shared package, with the decoder, holds:
  - opcode constants
  - NPC encodings (PLUS4/BRANCH/JUMP)
  - WDSel encodings
  - state encodings
  - trap_cause codes
- One sub-module, mc_wait_timer: the counter plus limit compare, with inputs start/busy/ready and output expired.

Test Plan:
- Reset, then `add` (0x00B50533) with zero-wait memory → ir_we in cycle 1, reg_we + pc_we + retire in cycle 4, npc_sel = 00.
- lw with mem_ready delayed 3 cycles in MEM → mem_req/addr_sel = 1 held stable for 4 cycles, reg_we in the following WB, 8 cycles total.
- beq, zero = 1 → pc_we in EXEC (cycle 3) with npc_sel = 01. Repeat with zero = 0 → npc_sel = 00.
- jal → WB asserts reg_we, pc_we and npc_sel = 10 in the same cycle; sw asserts mem_we only in MEM.
- Opcode 0x7F → TRAP after DECODE, trap_cause = 01, no further mem_req; mem_ready pulses ignored.
- mem_ready never arrives in FETCH, MEM_TIMEOUT = 16 → trap_cause = 10 after the 16th request cycle. Then assert rstn low mid-TRAP → IDLE with all outputs 0.
